// File: rtl/serial_pkg.sv
// Shared types and constants for the byte-serial UART transmitter.
// State codes, parity selection and frame-length arithmetic.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int START_BITS = 1;
  localparam int DATA_BITS  = 8;

  function automatic int frameClocks(input int divisor, input int parity, input int stopBits);
    return (START_BITS + DATA_BITS + ((parity != PAR_NONE) ? 1 : 0) + stopBits) * divisor;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period divider: one-cycle tick every DIVISOR clocks, realigned by restart.
module baud_tick_gen #(
  parameter int DIVISOR = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int W = $clog2(DIVISOR);
  localparam logic [W-1:0] RELOAD = W'(DIVISOR - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - W'(1);
    end
  end

  assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/serial_byte_tx.sv
// Byte-serial UART transmitter pulling bytes from the packet output buffer.
// A one-byte holding register lets frames leave back-to-back with no idle gap.
//
//   state     | meaning
//   ST_IDLE   | line high, waiting for the holding register to fill
//   ST_START  | start bit (low) for DIVISOR clocks
//   ST_DATA   | 8 data bits, LSB first
//   ST_PARITY | optional parity bit
//   ST_STOP   | STOPBITS stop bits (high); chains directly into ST_START
module serial_byte_tx
  import serial_pkg::*;
#(
  parameter int DIVISOR  = 8,
  parameter int PARITY   = PAR_NONE,
  parameter int STOPBITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] DataVal,
  input  logic       DataReady,
  output logic       DataNext,
  output logic       txd,
  output logic       Busy,
  output logic       Overrun
);

  if (DIVISOR < 2) begin : gBadDivisor
    $error("serial_byte_tx: DIVISOR must be >= 2");
  end
  if ((PARITY < PAR_NONE) || (PARITY > PAR_EVEN)) begin : gBadParity
    $error("serial_byte_tx: PARITY must be 0, 1 or 2");
  end
  if ((STOPBITS != 1) && (STOPBITS != 2)) begin : gBadStop
    $error("serial_byte_tx: STOPBITS must be 1 or 2");
  end

  localparam logic ODD_INV = (PARITY == PAR_ODD);

  state_t     state;
  logic [7:0] hold;
  logic [7:0] shifter;
  logic       holdValid;
  logic       parBit;
  logic [2:0] bitCnt;
  logic       tick;
  logic       restart;
  logic       lastStop;
  logic       transfer;
  logic       capture;

  baud_tick_gen #(.DIVISOR(DIVISOR)) uTick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // A byte arriving on the same edge hold empties is treated as an overrun.
  assign restart  = (state == ST_IDLE) && holdValid;
  assign lastStop = (bitCnt == 3'(STOPBITS - 1));
  assign transfer = holdValid && ((state == ST_IDLE) || ((state == ST_STOP) && tick && lastStop));
  assign capture  = DataReady && !holdValid;
  assign Busy     = (state != ST_IDLE) || holdValid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold      <= '0;
      shifter   <= '0;
      holdValid <= 1'b0;
      parBit    <= 1'b0;
      bitCnt    <= '0;
      txd       <= 1'b1;
      DataNext  <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      if (capture) begin
        hold      <= DataVal;
        holdValid <= 1'b1;
      end else if (transfer) begin
        holdValid <= 1'b0;
      end

      if (DataReady && holdValid) Overrun <= 1'b1;

      DataNext <= !DataReady && (!holdValid || transfer);

      if (transfer) begin
        shifter <= hold;
        parBit  <= (^hold) ^ ODD_INV;
      end

      case (state)
        ST_IDLE: begin
          if (holdValid) begin
            txd   <= 1'b0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            txd    <= shifter[0];
            bitCnt <= '0;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bitCnt == 3'd7) begin
              bitCnt <= '0;
              if (PARITY != PAR_NONE) begin
                txd   <= parBit;
                state <= ST_PARITY;
              end else begin
                txd   <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              shifter <= shifter >> 1;
              txd     <= shifter[1];
              bitCnt  <= bitCnt + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            txd    <= 1'b1;
            bitCnt <= '0;
            state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (lastStop) begin
              bitCnt <= '0;
              if (holdValid) begin
                txd   <= 1'b0;
                state <= ST_START;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              bitCnt <= bitCnt + 3'd1;
            end
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_byte_tx.sv
// Directed bench for serial_byte_tx: four DIVISOR=4 instances cover no/odd/even parity and two stop bits.
module tb_serial_byte_tx;
  import serial_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] dv   [4];
  logic       dr   [4];
  logic       dn   [4];
  logic       txd  [4];
  logic       busy [4];
  logic       ov   [4];

  int checks;
  int errors;

  logic       txdLog  [0:255];
  logic       dnLog   [0:255];
  logic       busyLog [0:255];
  logic       ovLog   [0:255];
  int         pulseQ  [$];
  logic [7:0] upBytes [0:7];
  int         forceCyc;
  logic [7:0] forceByte;

  serial_byte_tx #(.DIVISOR(4), .PARITY(0), .STOPBITS(1)) dut0 (
    .clk(clk), .rst(rst), .DataVal(dv[0]), .DataReady(dr[0]), .DataNext(dn[0]),
    .txd(txd[0]), .Busy(busy[0]), .Overrun(ov[0]));
  serial_byte_tx #(.DIVISOR(4), .PARITY(1), .STOPBITS(1)) dut1 (
    .clk(clk), .rst(rst), .DataVal(dv[1]), .DataReady(dr[1]), .DataNext(dn[1]),
    .txd(txd[1]), .Busy(busy[1]), .Overrun(ov[1]));
  serial_byte_tx #(.DIVISOR(4), .PARITY(2), .STOPBITS(1)) dut2 (
    .clk(clk), .rst(rst), .DataVal(dv[2]), .DataReady(dr[2]), .DataNext(dn[2]),
    .txd(txd[2]), .Busy(busy[2]), .Overrun(ov[2]));
  serial_byte_tx #(.DIVISOR(4), .PARITY(0), .STOPBITS(2)) dut3 (
    .clk(clk), .rst(rst), .DataVal(dv[3]), .DataReady(dr[3]), .DataNext(dn[3]),
    .txd(txd[3]), .Busy(busy[3]), .Overrun(ov[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected txd waveform of one frame at 4 clocks per bit; bit t = cycle t of the frame.
  function automatic logic [47:0] buildFrame(input logic [7:0] b, input int par, input int stops);
    logic [47:0] r;
    int n;
    int slot;
    r = '0;
    n = (9 + ((par != 0) ? 1 : 0) + stops) * 4;
    for (int t = 0; t < n; t++) begin
      slot = t / 4;
      if (slot == 0)                      r[t] = 1'b0;
      else if (slot <= 8)                 r[t] = b[slot-1];
      else if ((par != 0) && (slot == 9)) r[t] = (^b) ^ (par == 1);
      else                                r[t] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [47:0] logSlice(input int s, input int n);
    logic [47:0] r;
    r = '0;
    for (int t = 0; t < n; t++) r[t] = txdLog[s+t];
    return r;
  endfunction

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Upstream model: answers DataNext one cycle later with a one-cycle DataReady pulse.
  task automatic runUp(input int k, input int nCyc, input int nBytes);
    int   sent;
    logic dnS;
    logic drS;
    sent = 0;
    dnS  = 1'b0;
    drS  = 1'b0;
    pulseQ.delete();
    for (int c = 0; c < nCyc; c++) begin
      @(posedge clk);
      #1;
      if (c == forceCyc) begin
        dv[k] = forceByte;
        dr[k] = 1'b1;
      end else if (drS) begin
        dr[k] = 1'b0;
      end else if (dnS && (sent < nBytes)) begin
        dv[k] = upBytes[sent];
        dr[k] = 1'b1;
        sent++;
      end
      @(negedge clk);
      txdLog[c]  = txd[k];
      dnLog[c]   = dn[k];
      busyLog[c] = busy[k];
      ovLog[c]   = ov[k];
      if (dr[k]) pulseQ.push_back(c);
      dnS = dn[k];
      drS = dr[k];
    end
    #1;
    dr[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (txd[0] !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd[0]); end
    checks++;
    if (dn[0] !== 1'b0) begin errors++; $display("FAIL reset_datanext: got %b want 0", dn[0]); end
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy[0]); end
    checks++;
    if (ov[0] !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", ov[0]); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dn[0] !== 1'b1) begin errors++; $display("FAIL reset_release_datanext: got %b want 1", dn[0]); end
  endtask

  task automatic test_single_byte();
    int e;
    logic [47:0] obs;
    logic [47:0] exp;
    logic [7:0]  bits;
    doReset();
    upBytes[0] = 8'hA5;
    runUp(0, 60, 1);
    checks++;
    if (pulseQ.size() !== 1) begin
      errors++; $display("FAIL single_pulses: got %0d want 1", pulseQ.size());
    end else begin
      e = pulseQ[0];
      checks++;
      if (txdLog[e+1] !== 1'b1) begin errors++; $display("FAIL single_pre_start: txd %b want 1", txdLog[e+1]); end
      obs = logSlice(e + 2, 40);
      exp = buildFrame(8'hA5, 0, 1);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL single_frame: got %h want %h", obs, exp); end
      for (int i = 0; i < 8; i++) bits[i] = txdLog[e + 2 + 4 + 4*i + 1];
      checks++;
      if (bits !== 8'hA5) begin errors++; $display("FAIL single_data_bits: got %h want a5", bits); end
      checks++;
      if ((dnLog[e+1] !== 1'b0) || (dnLog[e+2] !== 1'b1)) begin
        errors++; $display("FAIL single_datanext: got %b%b want 01", dnLog[e+1], dnLog[e+2]);
      end
      checks++;
      if ((busyLog[e+41] !== 1'b1) || (busyLog[e+42] !== 1'b0) || (txdLog[e+42] !== 1'b1)) begin
        errors++; $display("FAIL single_end: busy %b%b txd %b want 10 1", busyLog[e+41], busyLog[e+42], txdLog[e+42]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e;
    logic [47:0] obs;
    logic [47:0] exp;
    doReset();
    upBytes[0] = 8'hFF; upBytes[1] = 8'hFF; upBytes[2] = 8'hFF; upBytes[3] = 8'h7F;
    runUp(0, 180, 4);
    checks++;
    if (pulseQ.size() !== 4) begin
      errors++; $display("FAIL b2b_captures: got %0d want 4", pulseQ.size());
    end else begin
      e = pulseQ[0];
      for (int i = 0; i < 4; i++) begin
        obs = logSlice(e + 2 + 40*i, 40);
        exp = buildFrame(upBytes[i], 0, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL b2b_frame%0d: got %h want %h", i, obs, exp); end
      end
      checks++;
      if ((busyLog[e+161] !== 1'b1) || (busyLog[e+162] !== 1'b0)) begin
        errors++; $display("FAIL b2b_length: busy %b%b want 10", busyLog[e+161], busyLog[e+162]);
      end
    end
    checks++;
    if (ovLog[179] !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", ovLog[179]); end
  endtask

  task automatic test_parity();
    int e;
    logic [47:0] obs;
    logic [47:0] exp;
    for (int k = 1; k <= 2; k++) begin
      doReset();
      upBytes[0] = 8'h03;
      runUp(k, 60, 1);
      checks++;
      if (pulseQ.size() !== 1) begin
        errors++; $display("FAIL parity%0d_pulses: got %0d want 1", k, pulseQ.size());
      end else begin
        e = pulseQ[0];
        checks++;
        if (txdLog[e+2+37] !== ((k == 1) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL parity%0d_bit: got %b want %b", k, txdLog[e+2+37], (k == 1));
        end
        obs = logSlice(e + 2, 44);
        exp = buildFrame(8'h03, k, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL parity%0d_frame: got %h want %h", k, obs, exp); end
        checks++;
        if ((busyLog[e+45] !== 1'b1) || (busyLog[e+46] !== 1'b0)) begin
          errors++; $display("FAIL parity%0d_length: busy %b%b want 10", k, busyLog[e+45], busyLog[e+46]);
        end
      end
    end
  endtask

  task automatic test_two_stop();
    int e;
    logic [47:0] obs;
    logic [47:0] exp;
    doReset();
    upBytes[0] = 8'h00; upBytes[1] = 8'h00;
    runUp(3, 110, 2);
    checks++;
    if (pulseQ.size() !== 2) begin
      errors++; $display("FAIL stop2_pulses: got %0d want 2", pulseQ.size());
    end else begin
      e = pulseQ[0];
      obs = logSlice(e + 2, 44);
      exp = buildFrame(8'h00, 0, 2);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL stop2_frame: got %h want %h", obs, exp); end
      checks++;
      if (txdLog[e+2+44] !== 1'b0) begin
        errors++; $display("FAIL stop2_next_start: txd %b want 0", txdLog[e+2+44]);
      end
    end
  endtask

  task automatic test_overrun();
    logic [47:0] obs;
    logic [47:0] exp;
    doReset();
    upBytes[0] = 8'h3C; upBytes[1] = 8'h81;
    forceCyc  = 20;
    forceByte = 8'hE7;
    runUp(0, 100, 2);
    forceCyc  = -1;
    checks++;
    if ((dnLog[19] !== 1'b0) || (busyLog[19] !== 1'b1)) begin
      errors++; $display("FAIL ovr_precondition: datanext %b busy %b want 0 1", dnLog[19], busyLog[19]);
    end
    checks++;
    if ((ovLog[20] !== 1'b0) || (ovLog[21] !== 1'b1) || (ovLog[99] !== 1'b1)) begin
      errors++; $display("FAIL ovr_flag: got %b%b%b want 011", ovLog[20], ovLog[21], ovLog[99]);
    end
    obs = logSlice(3, 40);
    exp = buildFrame(8'h3C, 0, 1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ovr_frame0: got %h want %h", obs, exp); end
    obs = logSlice(43, 40);
    exp = buildFrame(8'h81, 0, 1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL ovr_frame1: got %h want %h", obs, exp); end
    obs = logSlice(83, 17);
    checks++;
    if (obs !== 48'h1FFFF) begin errors++; $display("FAIL ovr_no_third: got %h want 1ffff", obs); end
  endtask

  task automatic test_reset_mid_frame();
    int e;
    logic [47:0] obs;
    logic [47:0] exp;
    upBytes[0] = 8'h5A;
    runUp(0, 20, 1);
    checks++;
    if ((txdLog[19] !== 1'b1) || (busyLog[19] !== 1'b1) || (ovLog[19] !== 1'b1)) begin
      errors++; $display("FAIL mid_before: txd %b busy %b ovr %b want 1 1 1", txdLog[19], busyLog[19], ovLog[19]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ((txd[0] !== 1'b1) || (dn[0] !== 1'b0) || (busy[0] !== 1'b0) || (ov[0] !== 1'b0)) begin
      errors++; $display("FAIL mid_reset: txd %b next %b busy %b ovr %b want 1 0 0 0", txd[0], dn[0], busy[0], ov[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dn[0] !== 1'b1) begin errors++; $display("FAIL mid_release_next: got %b want 1", dn[0]); end
    upBytes[0] = 8'hC3;
    runUp(0, 50, 1);
    checks++;
    if (pulseQ.size() !== 1) begin
      errors++; $display("FAIL mid_pulses: got %0d want 1", pulseQ.size());
    end else begin
      e = pulseQ[0];
      obs = logSlice(e + 2, 40);
      exp = buildFrame(8'hC3, 0, 1);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL mid_new_frame: got %h want %h", obs, exp); end
      checks++;
      if (busyLog[e+42] !== 1'b0) begin errors++; $display("FAIL mid_new_end: busy %b want 0", busyLog[e+42]); end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    forceCyc = -1;
    forceByte = 8'h00;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dv[k] = 8'h00;
      dr[k] = 1'b0;
    end
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_parity();
    test_two_stop();
    test_overrun();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
